// File: rtl/writeback_queue_if.sv
// Write-back handshake bundle: mem/alu producers in, register-file write port
// and queue status out.
interface writeback_queue_if #(
   parameter int DEPTH = 4
);
   logic                     mem_valid;
   logic [4:0]               mem_address;
   logic [63:0]              mem_data;
   logic                     mem_ready;
   logic                     alu_valid;
   logic [4:0]               alu_address;
   logic [63:0]              alu_data;
   logic                     alu_ready;
   logic [4:0]               rf_address;
   logic [63:0]              rf_data;
   logic                     rf_write;
   logic [31:0]              pending;
   logic [$clog2(DEPTH):0]   count;
   logic                     full;
   logic                     empty;

   modport slave (
      input  mem_valid, mem_address, mem_data, alu_valid, alu_address, alu_data,
      output mem_ready, alu_ready, rf_address, rf_data, rf_write, pending,
             count, full, empty
   );

   modport master (
      output mem_valid, mem_address, mem_data, alu_valid, alu_address, alu_data,
      input  mem_ready, alu_ready, rf_address, rf_data, rf_write, pending,
             count, full, empty
   );
endinterface

// File: rtl/writeback_queue.sv
// Write-back queue: merges mem/alu results (mem first) into an in-order circular
// buffer drained one entry per cycle into a registered register-file write port.

// One buffer slot; exposes its own one-hot pending contribution.
module wbq_slot (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_en,
   input  logic        clr,
   input  logic [4:0]  addr_in,
   input  logic [63:0] data_in,
   output logic [4:0]  addr,
   output logic [63:0] data,
   output logic [31:0] pend
);
   logic valid;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         addr  <= '0;
         data  <= '0;
      end else if (wr_en) begin
         valid <= 1'b1;
         addr  <= addr_in;
         data  <= data_in;
      end else if (clr) begin
         valid <= 1'b0;
      end
   end

   assign pend = valid ? (32'd1 << addr) : 32'd0;
endmodule

module writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   writeback_queue_if.slave  wb
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [4:0]  addr;
      logic [63:0] data;
   } wb_req_t;

   logic [PW-1:0]             wr_ptr, rd_ptr;
   logic [CW-1:0]             cnt;
   logic                      full, empty;
   logic                      mem_acc, alu_acc, push, pop;
   wb_req_t                   req;
   logic [DEPTH-1:0][4:0]     slot_addr;
   logic [DEPTH-1:0][63:0]    slot_data;
   logic [DEPTH-1:0][31:0]    slot_pend;
   logic [4:0]                rf_address;
   logic [63:0]               rf_data;
   logic                      rf_write;
   logic [31:0]               pend_acc;

   // Ready looks only at registered occupancy, never at this cycle's pop.
   assign full    = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign mem_acc = wb.mem_valid && !full;
   assign alu_acc = wb.alu_valid && !full && !wb.mem_valid;

   always_comb begin
      req = '0;
      if (mem_acc)      req = '{addr: wb.mem_address, data: wb.mem_data};
      else if (alu_acc) req = '{addr: wb.alu_address, data: wb.alu_data};
   end

   // Register 31 is hardwired zero: handshake completes, nothing is stored.
   assign push = (mem_acc || alu_acc) && (req.addr != 5'd31);
   assign pop  = !empty;

   for (genvar s = 0; s < DEPTH; s++) begin : g_slot
      wbq_slot u_slot (
         .clock   (clock),
         .reset   (reset),
         .wr_en   (push && (wr_ptr == PW'(s))),
         .clr     (pop && (rd_ptr == PW'(s))),
         .addr_in (req.addr),
         .data_in (req.data),
         .addr    (slot_addr[s]),
         .data    (slot_data[s]),
         .pend    (slot_pend[s])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         cnt        <= '0;
         rf_write   <= 1'b0;
         rf_address <= '0;
         rf_data    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         cnt      <= cnt + CW'(push) - CW'(pop);
         rf_write <= pop;
         if (pop) begin
            rf_address <= slot_addr[rd_ptr];
            rf_data    <= slot_data[rd_ptr];
         end
      end
   end

   always_comb begin
      pend_acc = '0;
      for (int s = 0; s < DEPTH; s++) pend_acc |= slot_pend[s];
      if (rf_write) pend_acc[rf_address] = 1'b1;
      pend_acc[31] = 1'b0;
   end

   assign wb.mem_ready  = !full;
   assign wb.alu_ready  = !full && !wb.mem_valid;
   assign wb.rf_address = rf_address;
   assign wb.rf_data    = rf_data;
   assign wb.rf_write   = rf_write;
   assign wb.pending    = pend_acc;
   assign wb.count      = cnt;
   assign wb.full       = full;
   assign wb.empty      = empty;
endmodule
